// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the byte FIFO subsystem.
package fifo_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W:0]    cnt_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W dual-port RAM with synchronous write and registered read.
module fifo_mem #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [PTR_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [PTR_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    import fifo_pkg::*;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // storage is never cleared; callers gate the write enable during reset
    always_ff @(posedge i_clock) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_rst) r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/modport_fifo.sv
// modport_fifo: single-clock byte FIFO with full/empty/almost_empty status.
// Optional sticky overflow/underflow ports when FIFO_ERR_FLAGS_EN is defined.
module modport_fifo #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int AE_LVL = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              almost_empty
);
    import fifo_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] L_AE   = (PW+1)'(AE_LVL);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_wr_acc, w_rd_acc;

    assign full         = r_count == L_FULL;
    assign empty        = r_count == '0;
    assign almost_empty = !empty && r_count <= L_AE;

    // a full FIFO still takes a write when the same-cycle read frees a slot
    assign w_rd_acc = read_enb && !empty;
    assign w_wr_acc = write_enb && (!full || w_rd_acc);

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_acc != w_rd_acc) r_count <= w_wr_acc ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_enb && !w_wr_acc) r_overflow <= 1'b1;
            if (read_enb && empty) r_underflow <= 1'b1;
        end
    end
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PW)) u_mem (
        .i_clock   (clock),
        .i_rst     (resetn),
        .i_wr_en   (w_wr_acc && !resetn),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc && !resetn),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );
endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: directed self-checking bench for modport_fifo.
module tb_modport_fifo;
    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty, almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif
    int n_chk = 0;
    int n_err = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    always #5 clock = ~clock;

    modport_fifo dut (
        .clock        (clock),
        .resetn       (resetn),
        .write_enb    (write_enb),
        .read_enb     (read_enb),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .almost_empty (almost_empty)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic re, input logic [7:0] d);
        write_enb = we;
        read_enb  = re;
        data_in   = d;
        @(posedge clock);
        #1;
        write_enb = 1'b0;
        read_enb  = 1'b0;
    endtask

    initial begin
        resetn = 1'b1;
        cyc(1'b1, 1'b0, 8'hEE);
        cyc(1'b1, 1'b0, 8'hEE);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 0);
        chk("rst_dout", data_out, 8'h00);
        resetn = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        chk("rst_nothing_stored", empty, 1);

        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 15) chk("fill_not_full15", full, 0);
        end
        chk("fill_full", full, 1);
        cyc(1'b1, 1'b0, 8'hFF);
        chk("fill_drop_full", full, 1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_data", data_out, i);
            if (i == 1) chk("drain_not_full", full, 0);
        end
        chk("drain_empty", empty, 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("empty_read_hold", data_out, 8'h10);

        cyc(1'b1, 1'b0, 8'hA5);
        chk("ae_empty0", empty, 0);
        chk("ae_set1", almost_empty, 1);
        cyc(1'b1, 1'b0, 8'h5A);
        chk("ae_clr", almost_empty, 0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ae_set2", almost_empty, 1);
        chk("ae_dout", data_out, 8'hA5);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ae_dout2", data_out, 8'h5A);
        chk("ae_empty1", empty, 1);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b1, 8'h77);
        chk("sim_full_keep", full, 1);
        chk("sim_full_oldest", data_out, 8'h20);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("sim_drain", data_out, (i == 16) ? 8'h77 : 8'(8'h20 + i));
        end
        chk("sim_drain_empty", empty, 1);
        cyc(1'b1, 1'b1, 8'h33);
        chk("sim_empty_cnt1", almost_empty, 1);
        chk("sim_empty_nonempty", empty, 0);
        chk("sim_empty_dout_hold", data_out, 8'h77);
        cyc(1'b0, 1'b1, 8'h00);
        chk("sim_empty_data", data_out, 8'h33);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'(8'hC0 + i));
            q.push_back(8'(8'hC0 + i));
        end
        for (int i = 0; i < 40; i++) begin
            logic we, re;
            logic [7:0] d;
            we = (i % 4) != 3;
            re = (i % 4) != 1;
            d  = 8'(8'h80 + i);
            if (re) exp_d = q.pop_front();
            if (we) q.push_back(d);
            cyc(we, re, d);
            if (re) chk("wrap_data", data_out, exp_d);
        end
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            cyc(1'b0, 1'b1, 8'h00);
            chk("wrap_tail", data_out, exp_d);
        end
        chk("wrap_empty", empty, 1);

        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
        resetn = 1'b1;
        cyc(1'b1, 1'b1, 8'h99);
        resetn = 1'b0;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_dout", data_out, 8'h00);
        chk("mid_rst_full", full, 0);
        cyc(1'b1, 1'b0, 8'h55);
        chk("mid_rst_cnt1", almost_empty, 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("mid_rst_data", data_out, 8'h55);
        chk("mid_rst_empty2", empty, 1);

`ifdef FIFO_ERR_FLAGS_EN
        chk("uf_clear", underflow, 0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("uf_set", underflow, 1);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b0, 1'b0, 8'h00);
        chk("uf_sticky", underflow, 1);
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        resetn = 1'b0;
        chk("uf_rst", underflow, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
